trap_sequencer: RTL and testbench
=================================

// Module: trap_sequencer
// PURPOSE
//  Sequences entry to and exit from machine-mode traps around the privileged/CSR unit in the M stage.
//  Decides when a pending interrupt is taken (take_irq_o), then flushes the pipeline for a fixed number of cycles.
//  Then issues one PC redirect to the trap vector (from mtvec/mcause) or to mepc (mret).
//  Then blocks further interrupts until the first handler instruction retires.
// PARAMETERS
//  FLUSH_CYCLES     1  cycles flush_o is held after a trap/mret is accepted (>=1)
//  IRQ_SYNC_STAGES  2  flop stages synchronising irq_external_i (>=2)
// PORTS
//  clk_i              in   1   clock
//  rst_i              in   1   asynchronous reset, active-high
//  instr_validM_i     in   1   valid instruction in M stage
//  stallM_i           in   1   M stage stalled
//  trapM_i            in   1   exception or taken irq raised in M (from privileged unit)
//  csr_mret_i         in   1   mret in M
//  mcause_i           in   mcause_t   cause written for the current trap
//  csr_mtvec_i        in   mtvec_t    base[31:2], mode[1:0] (0 direct, 1 vectored)
//  csr_mepc_i         in   32  return address for mret
//  mstatus_mie_i      in   1   global machine interrupt enable
//  irq_enabled_i      in   irqs_t     mip & mie (software/timer/external)
//  irq_external_i     in   1   asynchronous external interrupt line
//  instr_ret_i        in   1   instruction retired this cycle
//  irq_external_sync_o out 1   synchronised external irq (feeds mip.MEIP)
//  take_irq_o         out  1   take interrupt on current M instruction
//  flush_o            out  1   flush IF..M pipeline registers
//  pc_redirect_o      out  1   one-cycle fetch redirect strobe
//  redirect_pc_o      out  32  redirect target, valid with pc_redirect_o
//  busy_o             out  1   state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, redirect_pc_o=0, lockout=0, sync flops=0; reset mid-sequence aborts to IDLE.
//  States: IDLE -> FLUSH -> REDIRECT -> IDLE.
//  take_irq_o (combinational): IDLE & instr_validM_i & ~stallM_i & mstatus_mie_i & |irq_enabled_i & ~lockout & ~csr_mret_i.
//  IDLE accept: (trapM_i | csr_mret_i) & ~stallM_i.
//   - On accept, register target and load flush counter = FLUSH_CYCLES-1; go to FLUSH.
//   - Trap wins over simultaneous mret.
//  Trap target:
//   - direct mode, or exception (mcause.irq=0): {base,2'b00}.
//   - vectored mode with interrupt: {base,2'b00} + (trap_code<<2), 32-bit wrap.
//   - mtvec mode >=2 is treated as direct.
//  mret target: {csr_mepc_i[31:2],2'b00}.
//  FLUSH: flush_o=1; decrement counter; at 0 go to REDIRECT.
//  REDIRECT: pc_redirect_o=1, flush_o=1, redirect_pc_o=target for exactly 1 cycle; go to IDLE.
//   - On a trap (not mret), set lockout.
//  lockout clears on the first instr_ret_i seen in IDLE; exceptions are never blocked by lockout.
//  Latency: accept edge -> pc_redirect_o high FLUSH_CYCLES+0 cycles later (cycle FLUSH_CYCLES+1 counting accept as 1).
//  trapM_i/csr_mret_i while busy_o=1 are ignored (pipeline already flushed); a bind assertion flags them.
//  Stall held in IDLE: nothing accepted; take_irq_o=0.
//  irq_external_sync_o: IRQ_SYNC_STAGES-deep flop chain; no edge detection (level-sensitive).
// STRUCTURE
//  csr_pkg gets trap_seq_state_e {TS_IDLE,TS_FLUSH,TS_REDIRECT} and MTVEC_MODE_DIRECT/VECTORED constants.
//  Reuses mtvec_t, mcause_t, irqs_t.
//  One sub-module: irq_sync (parameterised N-flop synchroniser, async reset to 0).
//  Counter width $clog2(FLUSH_CYCLES+1).
// TESTING
//  1. Exception: mtvec=0x0000_1000 direct, trapM_i 1 cycle.
//     -> flush_o 1 cycle, then pc_redirect_o with 0x1000, busy_o 2 cycles.
//  2. Vectored timer irq: mtvec=0x0000_2001, MIE=1, irq_enabled.m_timer=1, valid M.
//     -> take_irq_o=1; mcause code 7 fed back; redirect 0x0000_201C.
//  3. mret with mepc=0x0000_0403 -> redirect 0x0000_0400; lockout not set.
//  4. Lockout: irq remains pending after redirect.
//     -> take_irq_o=0 until first instr_ret_i, then 1 on next valid M.
//  5. Stall/simultaneity:
//     - stallM_i=1 with pending irq -> take_irq_o=0, no accept.
//     - trapM_i & csr_mret_i together -> trap target used.
//  6. Reset mid-FLUSH (FLUSH_CYCLES=3): rst_i in 2nd flush cycle -> all outputs 0 immediately, IDLE after release.
//     - irq_external_i pulse appears on sync output after 2 clocks.

Source files
------------

// File: rtl/trap_sequencer_pkg.sv
// Shared CSR-side types for the trap sequencer: mtvec/mcause/irq layouts, FSM states, trap vector math.
// Latency: n/a (types and a pure combinational helper).
// Backpressure: n/a.
package trap_sequencer_pkg;

  // mtvec: base[31:2] and mode[1:0]
  typedef struct packed {
    logic [29:0] base;
    logic [1:0]  mode;
  } mtvec_t;

  // mcause: interrupt flag in bit 31, exception/interrupt code below it
  typedef struct packed {
    logic        irq;
    logic [30:0] code;
  } mcause_t;

  // Pending-and-enabled machine interrupts (mip & mie)
  typedef struct packed {
    logic m_external;
    logic m_timer;
    logic m_software;
  } irqs_t;

  typedef enum logic [1:0] {
    TS_IDLE     = 2'd0,
    TS_FLUSH    = 2'd1,
    TS_REDIRECT = 2'd2
  } trap_seq_state_e;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

  // Trap entry address. Only interrupts are vectored; any mode other than
  // VECTORED (including the reserved encodings) behaves as direct.
  function automatic logic [31:0] trap_target(input mtvec_t mtvec, input mcause_t mcause);
    logic [31:0] base;
    logic [31:0] offset;
    base   = {mtvec.base, 2'b00};
    offset = 32'(mcause.code) << 2;  // upper code bits fall off: 32-bit wrap
    if ((mtvec.mode == MTVEC_MODE_VECTORED) && mcause.irq) begin
      return base + offset;
    end
    return base;
  endfunction

endpackage

// File: rtl/trap_sequencer_irq_sync.sv
// N-flop synchroniser for a level-sensitive asynchronous interrupt line.
// Latency: N clocks from input change to output change.
// Backpressure: none; free-running, no edge detection.
//  clk_i, rst_i : clock, async active-high reset (chain clears to 0)
//  d_i          : asynchronous input
//  q_o          : synchronised output
module irq_sync #(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/trap_sequencer.sv
// Sequences M-mode trap entry / mret exit: irq take decision, pipeline flush, single PC redirect, irq lockout.
// Latency: redirect strobe FLUSH_CYCLES clocks after the accepting edge; flush_o held FLUSH_CYCLES+1 cycles.
// Backpressure: stallM_i holds off acceptance and take_irq_o; trap/mret requests while busy are dropped.
//  in : clk_i, rst_i, instr_validM_i, stallM_i, trapM_i, csr_mret_i, mcause_i, csr_mtvec_i,
//       csr_mepc_i, mstatus_mie_i, irq_enabled_i, irq_external_i, instr_ret_i
//  out: irq_external_sync_o, take_irq_o, flush_o, pc_redirect_o, redirect_pc_o[31:0], busy_o
import trap_sequencer_pkg::*;

module trap_sequencer #(
  parameter int FLUSH_CYCLES    = 1,
  parameter int IRQ_SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_validM_i,
  input  logic        stallM_i,
  input  logic        trapM_i,
  input  logic        csr_mret_i,
  input  mcause_t     mcause_i,
  input  mtvec_t      csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic        mstatus_mie_i,
  input  irqs_t       irq_enabled_i,
  input  logic        irq_external_i,
  input  logic        instr_ret_i,
  output logic        irq_external_sync_o,
  output logic        take_irq_o,
  output logic        flush_o,
  output logic        pc_redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        busy_o
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

  trap_seq_state_e state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     target_q, target_d;
  logic            is_trap_q, is_trap_d;
  logic            lockout_q, lockout_d;
  logic            busy_q, busy_d;
  logic            flush_q, flush_d;
  logic            redirect_q, redirect_d;
  logic [31:0]     redirect_pc_q, redirect_pc_d;

  logic            accept;

  irq_sync #(
    .N (IRQ_SYNC_STAGES)
  ) u_irq_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (irq_external_i),
    .q_o   (irq_external_sync_o)
  );

  // Gated by reset so every output reads 0 while reset is held, even with an irq pending.
  assign take_irq_o = ~rst_i & (state_q == TS_IDLE) & instr_validM_i & ~stallM_i &
                      mstatus_mie_i & (|irq_enabled_i) & ~lockout_q & ~csr_mret_i;

  assign accept = (trapM_i | csr_mret_i) & ~stallM_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    is_trap_d = is_trap_q;
    lockout_d = lockout_q;

    case (state_q)
      TS_IDLE: begin
        if (instr_ret_i) begin
          lockout_d = 1'b0;
        end
        if (accept) begin
          state_d   = TS_FLUSH;
          cnt_d     = CNT_LOAD;
          is_trap_d = trapM_i;
          // Trap takes priority over an mret seen in the same cycle.
          target_d  = trapM_i ? trap_target(csr_mtvec_i, mcause_i)
                              : (csr_mepc_i & 32'hFFFF_FFFC);
        end
      end
      TS_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = TS_REDIRECT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      TS_REDIRECT: begin
        state_d = TS_IDLE;
        // Hold off further interrupts until the handler's first instruction retires.
        if (is_trap_q) begin
          lockout_d = 1'b1;
        end
      end
      default: begin
        state_d = TS_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_d        = (state_d != TS_IDLE);
    flush_d       = busy_d;
    redirect_d    = (state_d == TS_REDIRECT);
    redirect_pc_d = redirect_d ? target_d : 32'h0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= TS_IDLE;
      cnt_q         <= '0;
      target_q      <= '0;
      is_trap_q     <= 1'b0;
      lockout_q     <= 1'b0;
      busy_q        <= 1'b0;
      flush_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      target_q      <= target_d;
      is_trap_q     <= is_trap_d;
      lockout_q     <= lockout_d;
      busy_q        <= busy_d;
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign busy_o        = busy_q;
  assign flush_o       = flush_q;
  assign pc_redirect_o = redirect_q;
  assign redirect_pc_o = redirect_pc_q;

  // Upstream must not raise trap/mret while a sequence is in flight; such requests are dropped.
  ap_no_req_while_busy: assert property (
    @(posedge clk_i) disable iff (rst_i)
      (state_q != TS_IDLE) |-> !(trapM_i || csr_mret_i)
  );

endmodule

// File: tb/tb_trap_sequencer.sv
import trap_sequencer_pkg::*;

module tb_trap_sequencer;

  localparam int FC = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_validM_i, stallM_i, trapM_i, csr_mret_i;
  mcause_t     mcause_i;
  mtvec_t      csr_mtvec_i;
  logic [31:0] csr_mepc_i;
  logic        mstatus_mie_i;
  irqs_t       irq_enabled_i;
  logic        irq_external_i, instr_ret_i;
  logic        irq_external_sync_o, take_irq_o, flush_o, pc_redirect_o, busy_o;
  logic [31:0] redirect_pc_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: cycles of busy remaining, lockout flag, kind of sequence in flight.
  int          m_left = 0;
  bit          m_lock = 0;
  bit          m_is_trap = 0;
  logic [31:0] sb_q[$];

  always #5 clk_i = ~clk_i;

  trap_sequencer #(.FLUSH_CYCLES(FC), .IRQ_SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_validM_i(instr_validM_i), .stallM_i(stallM_i),
    .trapM_i(trapM_i), .csr_mret_i(csr_mret_i), .mcause_i(mcause_i), .csr_mtvec_i(csr_mtvec_i),
    .csr_mepc_i(csr_mepc_i), .mstatus_mie_i(mstatus_mie_i), .irq_enabled_i(irq_enabled_i),
    .irq_external_i(irq_external_i), .instr_ret_i(instr_ret_i),
    .irq_external_sync_o(irq_external_sync_o), .take_irq_o(take_irq_o), .flush_o(flush_o),
    .pc_redirect_o(pc_redirect_o), .redirect_pc_o(redirect_pc_o), .busy_o(busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Interrupt take rule written straight from the enable conditions.
  function automatic logic model_take();
    return (m_left == 0) && instr_validM_i && !stallM_i && mstatus_mie_i &&
           (irq_enabled_i != 3'b000) && !m_lock && !csr_mret_i;
  endfunction

  function automatic logic [31:0] model_target();
    logic [31:0] base;
    if (trapM_i) begin
      base = {csr_mtvec_i.base, 2'b00};
      if (csr_mtvec_i.mode == 2'd1 && mcause_i.irq)
        return base + 32'(mcause_i.code) * 32'd4;
      return base;
    end
    return csr_mepc_i & 32'hFFFF_FFFC;
  endfunction

  task automatic model_edge();
    if (m_left > 0) begin
      if (m_left == 1 && m_is_trap) m_lock = 1;
      m_left--;
    end else begin
      if (instr_ret_i) m_lock = 0;
      if ((trapM_i || csr_mret_i) && !stallM_i) begin
        m_left    = FC + 1;
        m_is_trap = trapM_i;
        sb_q.push_back(model_target());
      end
    end
  endtask

  // One clock: inputs already driven (at a negedge). Ends at the following negedge.
  task automatic tick();
    #1;
    check("take_irq", 32'(take_irq_o), 32'(model_take()));
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    check("busy", 32'(busy_o), 32'(m_left > 0));
    check("flush", 32'(flush_o), 32'(m_left > 0));
    check("pc_redirect", 32'(pc_redirect_o), 32'(m_left == 1));
  endtask

  task automatic quiet();
    trapM_i = 0; csr_mret_i = 0; instr_ret_i = 0;
  endtask

  task automatic drain(input int n);
    quiet();
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_i = 1; quiet();
    m_left = 0; m_lock = 0; sb_q.delete();
    repeat (2) @(negedge clk_i);
    rst_i = 0;
  endtask

  // Scoreboard monitor: every redirect strobe must match the oldest predicted target.
  always @(negedge clk_i) begin
    if (!rst_i && pc_redirect_o) begin
      if (sb_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL redirect_unexpected: got 0x%08h expected no redirect", redirect_pc_o);
      end else begin
        check("redirect_pc", redirect_pc_o, sb_q.pop_front());
      end
    end
  end

  initial begin
    rst_i = 1; instr_validM_i = 0; stallM_i = 0; trapM_i = 0; csr_mret_i = 0;
    mcause_i = '0; csr_mtvec_i = '0; csr_mepc_i = '0; mstatus_mie_i = 0;
    irq_enabled_i = '0; irq_external_i = 0; instr_ret_i = 0;
    @(negedge clk_i);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_flush", 32'(flush_o), 0);
    check("rst_redirect", 32'(pc_redirect_o), 0);
    check("rst_redirect_pc", redirect_pc_o, 0);
    check("rst_sync", 32'(irq_external_sync_o), 0);
    rst_i = 0;
    @(negedge clk_i);

    // Exception, direct mtvec 0x1000
    csr_mtvec_i = 32'h0000_1000; mcause_i = {1'b0, 31'd2}; instr_validM_i = 1;
    trapM_i = 1;
    tick();
    drain(FC + 2);

    // Vectored timer interrupt -> 0x201C, sets lockout
    csr_mtvec_i = 32'h0000_2001; mstatus_mie_i = 1; irq_enabled_i = '0;
    irq_enabled_i.m_timer = 1; mcause_i = {1'b1, 31'd7};
    trapM_i = model_take();
    tick();
    drain(FC + 2);

    // Lockout: irq still pending, no take until a retire, then take again
    drain(3);
    instr_ret_i = 1; tick();
    drain(2);

    // mret to 0x403 -> 0x400, lockout left clear
    csr_mepc_i = 32'h0000_0403; csr_mret_i = 1; tick();
    drain(FC + 3);

    // Stall with pending irq and a trap request: nothing accepted
    stallM_i = 1; trapM_i = 1; tick(); tick();
    stallM_i = 0; quiet(); tick();

    // Trap and mret together: trap target wins
    csr_mtvec_i = 32'h0000_3000; csr_mepc_i = 32'h0000_0500; mcause_i = {1'b0, 31'd11};
    trapM_i = 1; csr_mret_i = 1; tick();
    drain(FC + 2);

    // Reset in the second flush cycle
    mstatus_mie_i = 0; trapM_i = 1; tick();
    quiet(); tick();
    rst_i = 1; #1;
    check("midrst_busy", 32'(busy_o), 0);
    check("midrst_flush", 32'(flush_o), 0);
    check("midrst_redirect", 32'(pc_redirect_o), 0);
    check("midrst_redirect_pc", redirect_pc_o, 0);
    check("midrst_take", 32'(take_irq_o), 0);
    m_left = 0; m_lock = 0; sb_q.delete();
    @(negedge clk_i); rst_i = 0;
    drain(2);

    // External irq synchroniser: level appears after 2 clocks
    irq_external_i = 1;
    @(posedge clk_i); #1 check("sync_1clk", 32'(irq_external_sync_o), 0);
    @(posedge clk_i); #1 check("sync_2clk", 32'(irq_external_sync_o), 1);
    irq_external_i = 0;
    @(posedge clk_i); #1 check("sync_fall_1clk", 32'(irq_external_sync_o), 1);
    @(posedge clk_i); #1 check("sync_fall_2clk", 32'(irq_external_sync_o), 0);
    @(negedge clk_i);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      quiet();
      instr_validM_i = ($urandom_range(0, 3) != 0);
      stallM_i       = ($urandom_range(0, 4) == 0);
      mstatus_mie_i  = ($urandom_range(0, 3) != 0);
      irq_enabled_i  = 3'($urandom_range(0, 7));
      irq_external_i = $urandom_range(0, 1);
      instr_ret_i    = ($urandom_range(0, 5) == 0);
      csr_mepc_i     = $urandom;
      csr_mtvec_i    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFD : $urandom;
      if (m_left == 0) begin
        csr_mret_i = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 7) == 0) begin
          trapM_i  = 1;
          mcause_i = {1'b0, 31'($urandom_range(0, 15))};
        end else if (model_take() && $urandom_range(0, 1) == 1) begin
          trapM_i  = 1;
          mcause_i = {1'b1, irq_enabled_i.m_external ? 31'd11 :
                            irq_enabled_i.m_software ? 31'd3 : 31'd7};
        end
      end
      tick();
    end
    drain(FC + 2);
    check("sb_empty", 32'(sb_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
